// File: rtl/s_term_ram_io_pkg.sv
// Shared types, constants and helpers for the RAM_IO south-edge terminal.
// Holds the mode/state encodings, the LFSR taps and the wire reversal map.
package s_term_ram_io_pkg;

    localparam int unsigned WIRE_W = 36;
    localparam int unsigned TAP_HI = 35;
    localparam int unsigned TAP_LO = 24;
    localparam logic [WIRE_W-1:0] DEFAULT_SEED = 36'h0_0000_0001;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_REG     = 2'd1,
        MODE_PATTERN = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Fibonacci x^36+x^25+1 step; xor_en folds din in for MISR use.
    function automatic logic [WIRE_W-1:0] lfsr_step(input logic [WIRE_W-1:0] q,
                                                    input logic [WIRE_W-1:0] din,
                                                    input logic              xor_en);
        logic [WIRE_W-1:0] nxt;
        nxt = {q[WIRE_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
        if (xor_en) begin
            nxt = nxt ^ din;
        end
        return nxt;
    endfunction

    // Reverse bit order inside each wire group of {S4,S2END,S2MID,S1}.
    function automatic logic [WIRE_W-1:0] rev_map(input logic [WIRE_W-1:0] v);
        logic [WIRE_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[i] = v[3-i];
        end
        for (int unsigned i = 0; i < 8; i++) begin
            r[4+i]  = v[11-i];
            r[12+i] = v[19-i];
        end
        for (int unsigned i = 0; i < 16; i++) begin
            r[20+i] = v[35-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/s_term_ram_io_loopback_bist_lfsr.sv
// 36-bit shift register used both as pattern generator (xor_en=0) and MISR (xor_en=1).
module term_lfsr36
    import s_term_ram_io_pkg::*;
#(
    parameter logic [WIRE_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [WIRE_W-1:0] data_in,
    input  logic              xor_en,
    output logic [WIRE_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INIT;
        end else if (load) begin
            q <= INIT;
        end else if (en) begin
            q <= lfsr_step(q, data_in, xor_en);
        end
    end

endmodule

// File: rtl/s_term_ram_io_loopback_bist.sv
// South-edge RAM_IO terminal: reversed loopback of S*END onto N*BEG with an
// optional register stage and an LFSR/MISR continuity test of the vertical wires.
module s_term_ram_io_loopback_bist
    import s_term_ram_io_pkg::*;
#(
    parameter int unsigned       TEST_LEN = 256,
    parameter int unsigned       LOOP_LAT = 2,
    parameter logic [WIRE_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic        UserCLK,
    input  logic        rst_n,
    input  logic [3:0]  S1END,
    input  logic [7:0]  S2MID,
    input  logic [7:0]  S2END,
    input  logic [15:0] S4END,
    output logic [3:0]  N1BEG,
    output logic [7:0]  N2BEG,
    output logic [7:0]  N2BEGb,
    output logic [15:0] N4BEG,
    input  logic [1:0]  mode,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [35:0] signature
);

    localparam logic [16:0] LEN     = 17'(TEST_LEN);
    localparam logic [16:0] LAT     = 17'(LOOP_LAT);
    localparam logic [16:0] LAST_CY = 17'(TEST_LEN + LOOP_LAT - 1);

    logic [WIRE_W-1:0] in_vec, rev_in, out_vec;
    logic [WIRE_W-1:0] loop_q, gen_q, misr_q;
    logic [WIRE_W-1:0] sig_q, sig_d;
    logic [16:0]       cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              pattern_mode, in_run, launch, gen_en, cap_en, last_cy;

    assign in_vec = {S4END, S2END, S2MID, S1END};
    assign rev_in = rev_map(in_vec);

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            loop_q <= '0;
        end else begin
            loop_q <= rev_in;
        end
    end

    always_comb begin
        pattern_mode = (mode == MODE_PATTERN);
        in_run       = (state_q == ST_RUN);
        launch       = pattern_mode && start && (state_q != ST_RUN);
        gen_en       = in_run && (cnt_q < LEN);
        cap_en       = in_run && (cnt_q >= LAT) && (cnt_q <= LAST_CY);
        last_cy      = in_run && (cnt_q == LAST_CY);
    end

    term_lfsr36 #(.INIT(SEED)) u_gen (
        .clk     (UserCLK),
        .rst_n   (rst_n),
        .load    (launch),
        .en      (gen_en),
        .data_in ('0),
        .xor_en  (1'b0),
        .q       (gen_q)
    );

    term_lfsr36 #(.INIT('0)) u_misr (
        .clk     (UserCLK),
        .rst_n   (rst_n),
        .load    (launch),
        .en      (cap_en),
        .data_in (in_vec),
        .xor_en  (1'b1),
        .q       (misr_q)
    );

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        sig_d   = sig_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end else if (!pattern_mode) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!pattern_mode) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                    if (last_cy) begin
                        // Signature must include the capture made on this same edge.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        sig_d   = lfsr_step(misr_q, in_vec, 1'b1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (mode)
            MODE_REG:     out_vec = loop_q;
            MODE_PATTERN: out_vec = gen_en ? rev_map(gen_q) : '0;
            default:      out_vec = rev_in;
        endcase
    end

    assign N1BEG     = out_vec[3:0];
    assign N2BEG     = out_vec[11:4];
    assign N2BEGb    = out_vec[19:12];
    assign N4BEG     = out_vec[35:20];
    assign busy      = in_run;
    assign done      = done_q;
    assign signature = sig_q;

endmodule

// File: doc/s_term_ram_io_loopback_bist.md
Name: s_term_ram_io_loopback_bist

Overview:
- South-edge terminal for the RAM_IO column. It terminates the south-going wire ends (S1END, S2MID, S2END, S4END) and returns them on the north-going begin wires (N1BEG, N2BEG, N2BEGb, N4BEG).
- It adds an optional one-cycle register stage on that return path.
- It adds a built-in wire test: an LFSR pattern is driven north, and a MISR compresses whatever comes back south.
- It sits in the bottom row, mirroring the north-edge terminal, and gives in-field continuity checking of the vertical routing.

Parameters:
- TEST_LEN, 256, number of pattern cycles driven per test run (legal range 1..65535).
- LOOP_LAT, 2, cycles from pattern leaving on N*BEG to it returning on S*END; MISR capture is delayed by this amount (legal range 0..15).
- SEED, 36'h0_0000_0001, LFSR reset/start value; must be nonzero.

Ports:
- UserCLK  input  1  fabric user clock
- rst_n  input  1  asynchronous active-low reset
- S1END  input  4  single-hop south wire ends
- S2MID  input  8  double-hop south wire midpoints
- S2END  input  8  double-hop south wire ends
- S4END  input  16  quad-hop south wire ends
- N1BEG  output  4  single-hop north wire begins
- N2BEG  output  8  double-hop north begins (fed from S2MID)
- N2BEGb  output  8  double-hop north begins (fed from S2END)
- N4BEG  output  16  quad-hop north begins
- mode  input  2  0=BYPASS, 1=REGISTERED, 2=PATTERN, 3=reserved (treated as BYPASS)
- start  input  1  single-cycle pulse; launches a test when in PATTERN mode and IDLE
- busy  output  1  high while in RUN
- done  output  1  sticky; high after a run completes
- signature  output  36  final MISR value

Behaviour:
- Fixed index reversal:
  - N1BEG[i]=S1END[3-i]
  - N2BEG[i]=S2MID[7-i]
  - N2BEGb[i]=S2END[7-i]
  - N4BEG[i]=S4END[15-i]
- Packed vectors:
  - in_vec = {S4END,S2END,S2MID,S1END} (36 bits)
  - out_vec = {N4BEG,N2BEGb,N2BEG,N1BEG}
- Reset: asynchronous, no clock needed.
  - Loop register = 0; LFSR = SEED; MISR = 0.
  - state = IDLE; busy = 0; done = 0; signature = 0.
  - In any mode other than BYPASS, out_vec = 0 while rst_n is low.
- BYPASS: out_vec is the combinational reversed mapping of in_vec, independent of the clock and of reset.
- REGISTERED: out_vec = reversed in_vec registered on the rising edge of UserCLK (1-cycle latency). The loop register updates in every mode.
- PATTERN, IDLE or DONE: out_vec = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: start=1 and mode=2. On that edge: LFSR<=SEED, MISR<=0, cnt<=0, done<=0.
  - RUN: cnt increments each cycle.
    - For cnt < TEST_LEN, out_vec = the LFSR state with its reversed mapping (LFSR bit j drives the out_vec bit that in_vec bit j would), and the LFSR advances.
    - For cnt >= TEST_LEN, out_vec = 0.
    - The MISR captures in_vec when LOOP_LAT <= cnt < TEST_LEN+LOOP_LAT.
  - RUN -> DONE: on the edge where cnt = TEST_LEN+LOOP_LAT-1. On that edge: signature <= final MISR (including that cycle's capture), done <= 1, busy <= 0.
  - DONE -> RUN: on a new start in mode 2 (same actions as IDLE -> RUN).
  - DONE -> IDLE: on mode != 2; done is retained.
- LFSR: Fibonacci, polynomial x^36+x^25+1, shifts toward MSB, feedback = bit35 ^ bit24 into bit0.
- MISR: same shift and feedback, then XOR with in_vec.
- Boundaries:
  - start while RUN: ignored.
  - start in modes 0, 1 or 3: ignored.
  - mode changes away from 2 during RUN: abort to IDLE, done stays 0, signature keeps its previous value.
  - rst_n asserted mid-run: immediate return to reset values.
  - cnt is 17 bits wide; it cannot wrap at the maximum TEST_LEN+LOOP_LAT.
- Timing: busy goes high the cycle after start is sampled; done goes high TEST_LEN+LOOP_LAT cycles after busy rises.

Decomposition:
- Package s_term_ram_io_pkg:
  - mode enum: MODE_BYPASS, MODE_REG, MODE_PATTERN
  - FSM state enum
  - WIRE_W=36
  - POLY tap constants (35, 24)
  - default SEED
- Sub-module term_lfsr36:
  - Ports: clk, rst_n, load, en, data_in, xor_en, q.
  - Instantiated twice: generator (xor_en=0) and MISR (xor_en=1).

Test Plan:
- Bypass: mode=0, S4END=16'h0001, S1END=4'h1 -> same cycle N4BEG=16'h8000, N1BEG=4'h8; no clock edge required.
- Registered: mode=1, S2MID=8'h01 applied at edge k -> N2BEG=8'h80 after edge k+1; S2END=8'hF0 -> N2BEGb=8'h0F one cycle later.
- Pattern with model loopback:
  - Setup: TEST_LEN=4, LOOP_LAT=2; bench delays out_vec by 2 cycles and returns it reversed onto in_vec; pulse start.
  - Required: busy high for exactly 6 cycles, done rises on the 6th edge after busy, signature equals the reference-model MISR over LFSR states SEED..step3.
  - Stuck-at check: forcing S4END[0]=0 changes the signature.
- Abort: mode 2->1 at RUN cycle 3 -> state IDLE next edge, busy=0, done=0, signature unchanged (0 after reset).
- Reset mid-run: rst_n low asynchronously during RUN -> busy=0, done=0, out_vec=0 immediately; after release, a restart produces the same signature as a clean run.
- Ignored start: start pulse with mode=0, and a second start during RUN -> no state change, and cycle count to done is unaffected.
